// File: rtl/pc_stack_unit.sv
// pc_stack_unit: per-core program counter with NZP flags, conditional branch and CALL/RET return stack.
// Latency: next_pc is combinational; current_pc, stack_count and stack_error change one edge after pc_update.
// Backpressure: none, every pc_update strobe commits. The return stack is built only with `define PC_CALL_STACK_EN.
module pc_stack_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  IMM_WIDTH   = 8,
    parameter int                  STACK_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pc_update,
    input  logic [2:0]                           decoded_nzp,
    input  logic [IMM_WIDTH-1:0]                 decoded_immediate,
    input  logic                                 decoded_nzp_write_enable,
    input  logic [2:0]                           nzp_input_data,
    input  logic                                 decoded_pc_mux,
    input  logic                                 decoded_call,
    input  logic                                 decoded_ret,
    input  logic                                 clear_error,
    output logic [PC_WIDTH-1:0]                  current_pc,
    output logic [PC_WIDTH-1:0]                  next_pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
    output logic                                 stack_error
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [PC_WIDTH-1:0] r_pc;
    logic [2:0]          r_nzp;
    logic [PC_WIDTH-1:0] w_inc;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_branch_taken;

    assign current_pc     = r_pc;
    assign w_inc          = r_pc + PC_WIDTH'(1);
    // Branch looks only at the registered flags; a same-cycle NZP write lands next edge.
    assign w_branch_taken = decoded_pc_mux && ((r_nzp & decoded_nzp) != 3'b000);

    // Immediate is zero-extended or truncated to the PC width.
    generate
        if (IMM_WIDTH >= PC_WIDTH) begin : g_imm_trunc
            assign w_target = decoded_immediate[PC_WIDTH-1:0];
        end else begin : g_imm_zext
            assign w_target = {{(PC_WIDTH-IMM_WIDTH){1'b0}}, decoded_immediate};
        end
    endgenerate

    // NZP flags load whenever the decoder asks, independent of the update strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nzp <= 3'b000;
        end else if (decoded_nzp_write_enable) begin
            r_nzp <= nzp_input_data;
        end
    end

    // PC commits the selected next value on each update strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (pc_update) begin
            r_pc <= next_pc;
        end
    end

`ifdef PC_CALL_STACK_EN
    localparam int            IW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CW-1:0] FULL_C = CW'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [CW-1:0]       r_count;
    logic                r_error;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_err;
    logic [IW-1:0]       w_push_idx;
    logic [IW-1:0]       w_top_idx;

    // Entries are indexed by count: push writes slot[count], top of stack is slot[count-1].
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_C);
    assign w_push_idx = IW'(r_count);
    assign w_top_idx  = IW'(r_count - CW'(1));

    // Priority select: RET, then CALL, then taken branch, else sequential.
    always_comb begin
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_err   = 1'b0;
        next_pc = w_inc;
        if (decoded_ret) begin
            if (!w_empty) begin
                next_pc = r_stack[w_top_idx];
                w_pop   = 1'b1;
            end else begin
                w_err   = 1'b1;
            end
        end else if (decoded_call) begin
            if (!w_full) begin
                next_pc = w_target;
                w_push  = 1'b1;
            end else begin
                w_err   = 1'b1;
            end
        end else if (w_branch_taken) begin
            next_pc = w_target;
        end
    end

    // Stack depth counter moves only on committed push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (pc_update) begin
            if (w_push) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky error: a new error on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (pc_update && w_err) begin
            r_error <= 1'b1;
        end else if (clear_error) begin
            r_error <= 1'b0;
        end
    end

    // Return-address storage, no reset; contents above the count are don't-care.
    always_ff @(posedge clk) begin
        if (reset && pc_update && w_push) begin
            r_stack[w_push_idx] <= w_inc;
        end
    end

    assign stack_count = r_count;
    assign stack_error = r_error;
`else
    logic w_unused;

    // Without the stack, CALL/RET fall through to branch or sequential.
    always_comb begin
        next_pc = w_inc;
        if (w_branch_taken) begin
            next_pc = w_target;
        end
    end

    assign stack_count = '0;
    assign stack_error = 1'b0;
    assign w_unused    = ^{clear_error, decoded_call, decoded_ret};
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench for pc_stack_unit (RESET_PC=8'h10, depth 4).
// Latency: expectations are queued with each stimulus cycle and compared after the edge.
// Backpressure: n/a; stimulus is free-running on core clock edges.
module tb_pc_stack_unit;

    logic       clk;
    logic       reset;
    logic       pc_update;
    logic [2:0] decoded_nzp;
    logic [7:0] decoded_immediate;
    logic       decoded_nzp_write_enable;
    logic [2:0] nzp_input_data;
    logic       decoded_pc_mux;
    logic       decoded_call;
    logic       decoded_ret;
    logic       clear_error;
    logic [7:0] current_pc;
    logic [7:0] next_pc;
    logic [2:0] stack_count;
    logic       stack_error;

    typedef struct {
        string      nm;
        logic [7:0] pc;
        logic [2:0] cnt;
        logic       err;
    } rec_t;

    rec_t sb[$];
    rec_t obs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    pc_stack_unit #(
        .PC_WIDTH    (8),
        .IMM_WIDTH   (8),
        .STACK_DEPTH (4),
        .RESET_PC    (8'h10)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .pc_update                (pc_update),
        .decoded_nzp              (decoded_nzp),
        .decoded_immediate        (decoded_immediate),
        .decoded_nzp_write_enable (decoded_nzp_write_enable),
        .nzp_input_data           (nzp_input_data),
        .decoded_pc_mux           (decoded_pc_mux),
        .decoded_call             (decoded_call),
        .decoded_ret              (decoded_ret),
        .clear_error              (clear_error),
        .current_pc               (current_pc),
        .next_pc                  (next_pc),
        .stack_count              (stack_count),
        .stack_error              (stack_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        pc_update                = 1'b0;
        decoded_nzp              = 3'b000;
        decoded_immediate        = 8'h00;
        decoded_nzp_write_enable = 1'b0;
        nzp_input_data           = 3'b000;
        decoded_pc_mux           = 1'b0;
        decoded_call             = 1'b0;
        decoded_ret              = 1'b0;
        clear_error              = 1'b0;
    endtask

    task automatic drive(input logic upd, input logic ret, input logic call, input logic mux,
                         input logic [2:0] mask, input logic [7:0] imm,
                         input logic we, input logic [2:0] nzd, input logic clr);
        pc_update                = upd;
        decoded_ret              = ret;
        decoded_call             = call;
        decoded_pc_mux           = mux;
        decoded_nzp              = mask;
        decoded_immediate        = imm;
        decoded_nzp_write_enable = we;
        nzp_input_data           = nzd;
        clear_error              = clr;
    endtask

    // Queue the expectation, take one edge, record what the DUT shows afterwards.
    task automatic tick_rec(input string nm, input logic [7:0] epc, input logic [2:0] ecnt, input logic eerr);
        rec_t e;
        rec_t o;
        e.nm = nm; e.pc = epc; e.cnt = ecnt; e.err = eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        o.nm = nm; o.pc = current_pc; o.cnt = stack_count; o.err = stack_error;
        obs.push_back(o);
        clear_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        drive(1, 0, 1, 1, 3'b111, 8'hAA, 1, 3'b111, 0);
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
        n_chk++;
        if (current_pc !== 8'h10) $display("FAIL reset_pc: got %h need 10", current_pc);
        else n_pass++;
        n_chk++;
        if (stack_count !== 3'd0) $display("FAIL reset_count: got %0d need 0", stack_count);
        else n_pass++;
        n_chk++;
        if (stack_error !== 1'b0) $display("FAIL reset_err: got %b need 0", stack_error);
        else n_pass++;
        n_chk++;
        if (next_pc !== 8'h11) $display("FAIL reset_next_pc: got %h need 11", next_pc);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        rec_t e;
        rec_t o;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0);
            tick_rec("seq", 8'(8'h11 + i), 3'd0, 1'b0);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        rec_t e;
        rec_t o;
        drive(0, 0, 0, 0, 3'b000, 8'h00, 1, 3'b010, 0);
        tick_rec("nzp_write", 8'h13, 3'd0, 1'b0);
        drive(1, 0, 0, 1, 3'b010, 8'h40, 0, 3'b000, 0);
        tick_rec("br_taken", 8'h40, 3'd0, 1'b0);
        drive(1, 0, 0, 1, 3'b101, 8'h40, 0, 3'b000, 0);
        tick_rec("br_not_taken", 8'h41, 3'd0, 1'b0);
        drive(1, 0, 0, 1, 3'b101, 8'h60, 1, 3'b101, 0);
        #1;
        n_chk++;
        if (next_pc !== 8'h42) $display("FAIL br_same_cycle_next: got %h need 42", next_pc);
        else n_pass++;
        tick_rec("br_same_cycle_nzp", 8'h42, 3'd0, 1'b0);
        drive(1, 0, 0, 1, 3'b101, 8'h60, 0, 3'b000, 0);
        tick_rec("br_after_nzp", 8'h60, 3'd0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_priority();
        rec_t e;
        rec_t o;
        drive(1, 0, 0, 1, 3'b001, 8'hFF, 0, 3'b000, 0);
        tick_rec("br_to_ff", 8'hFF, 3'd0, 1'b0);
        drive(1, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0);
        tick_rec("wrap", 8'h00, 3'd0, 1'b0);
        drive(1, 0, 1, 0, 3'b000, 8'h10, 0, 3'b000, 0);
`ifdef PC_CALL_STACK_EN
        tick_rec("call_before_prio", 8'h10, 3'd1, 1'b0);
        drive(1, 1, 1, 1, 3'b101, 8'h77, 0, 3'b000, 0);
        tick_rec("prio_ret_wins", 8'h01, 3'd0, 1'b0);
`else
        tick_rec("call_ignored", 8'h01, 3'd0, 1'b0);
        drive(1, 1, 1, 1, 3'b101, 8'h77, 0, 3'b000, 0);
        tick_rec("prio_branch", 8'h77, 3'd0, 1'b0);
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        rec_t       e;
        rec_t       o;
        logic [7:0] hold_pc;
`ifdef PC_CALL_STACK_EN
        hold_pc = 8'h01;
`else
        hold_pc = 8'h77;
`endif
        drive(0, 0, 0, 1, 3'b101, 8'h5A, 0, 3'b000, 0);
        #1;
        n_chk++;
        if (next_pc !== 8'h5A) $display("FAIL hold_next_a: got %h need 5a", next_pc);
        else n_pass++;
        decoded_immediate = 8'h5B;
        #1;
        n_chk++;
        if (next_pc !== 8'h5B) $display("FAIL hold_next_b: got %h need 5b", next_pc);
        else n_pass++;
        tick_rec("hold_no_update", hold_pc, 3'd0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask

`ifdef PC_CALL_STACK_EN
    task automatic test_calls();
        rec_t e;
        rec_t o;
        drive(1, 0, 0, 1, 3'b101, 8'h05, 0, 3'b000, 0); tick_rec("br_to_05", 8'h05, 3'd0, 1'b0);
        drive(1, 0, 1, 0, 3'b000, 8'h20, 0, 3'b000, 0); tick_rec("call_20", 8'h20, 3'd1, 1'b0);
        drive(1, 0, 1, 0, 3'b000, 8'h30, 0, 3'b000, 0); tick_rec("call_30", 8'h30, 3'd2, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("ret_21", 8'h21, 3'd1, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("ret_06", 8'h06, 3'd0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        rec_t e;
        rec_t o;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 3'b000, 8'(8'h30 + i), 0, 3'b000, 0);
            tick_rec("fill", 8'(8'h30 + i), 3'(i + 1), 1'b0);
        end
        drive(1, 0, 1, 0, 3'b000, 8'h50, 0, 3'b000, 0); tick_rec("overflow", 8'h34, 3'd4, 1'b1);
        drive(0, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000, 1); tick_rec("clear_after_ovf", 8'h34, 3'd4, 1'b0);
        drive(0, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000, 1); tick_rec("clear_no_err", 8'h34, 3'd4, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("pop_33", 8'h33, 3'd3, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("pop_32", 8'h32, 3'd2, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("pop_31", 8'h31, 3'd1, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("pop_07", 8'h07, 3'd0, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("underflow", 8'h08, 3'd0, 1'b1);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 1); tick_rec("err_beats_clear", 8'h09, 3'd0, 1'b1);
        drive(0, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000, 1); tick_rec("clear_err", 8'h09, 3'd0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask
`else
    task automatic test_macro_off();
        rec_t e;
        rec_t o;
        drive(1, 0, 0, 1, 3'b101, 8'h07, 0, 3'b000, 0); tick_rec("br_to_07", 8'h07, 3'd0, 1'b0);
        drive(1, 0, 1, 0, 3'b000, 8'h50, 0, 3'b000, 0); tick_rec("call_off", 8'h08, 3'd0, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0); tick_rec("ret_off", 8'h09, 3'd0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_mid();
        rec_t e;
        rec_t o;
        drive(1, 0, 1, 0, 3'b000, 8'h44, 0, 3'b000, 0);
`ifdef PC_CALL_STACK_EN
        tick_rec("call_pre_reset", 8'h44, 3'd1, 1'b0);
`else
        tick_rec("call_pre_reset", 8'h0A, 3'd0, 1'b0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if ({current_pc, stack_count, stack_error} !== {8'h10, 3'd0, 1'b0})
            $display("FAIL async_reset: got pc=%h cnt=%0d err=%b need pc=10 cnt=0 err=0", current_pc, stack_count, stack_error);
        else n_pass++;
        drive(1, 0, 0, 1, 3'b111, 8'h99, 0, 3'b000, 0);
        @(posedge clk);
        #1;
        clear_inputs();
        reset = 1'b1;
        n_chk++;
        if (current_pc !== 8'h10) $display("FAIL reset_discard: got %h need 10", current_pc);
        else n_pass++;
        drive(1, 0, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0);
        tick_rec("first_after_reset", 8'h11, 3'd0, 1'b0);
        drive(1, 1, 0, 0, 3'b000, 8'h00, 0, 3'b000, 0);
`ifdef PC_CALL_STACK_EN
        tick_rec("stack_discarded", 8'h12, 3'd0, 1'b1);
        drive(1, 0, 0, 1, 3'b111, 8'h99, 0, 3'b000, 0);
        tick_rec("nzp_cleared", 8'h13, 3'd0, 1'b1);
`else
        tick_rec("stack_discarded", 8'h12, 3'd0, 1'b0);
        drive(1, 0, 0, 1, 3'b111, 8'h99, 0, 3'b000, 0);
        tick_rec("nzp_cleared", 8'h13, 3'd0, 1'b0);
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = obs.pop_front(); n_chk++;
            if ({o.pc, o.cnt, o.err} !== {e.pc, e.cnt, e.err})
                $display("FAIL %s: got pc=%h cnt=%0d err=%b need pc=%h cnt=%0d err=%b", e.nm, o.pc, o.cnt, o.err, e.pc, e.cnt, e.err);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap_priority();
        test_hold();
`ifdef PC_CALL_STACK_EN
        test_calls();
        test_overflow();
`else
        test_macro_off();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
